// File: rtl/tx_byte_fifo_pkg.sv
// tx_byte_fifo shared definitions: default geometry,
// input FSM encoding and the occupancy width helper.
package tx_byte_fifo_pkg;

    localparam int DEF_DEPTH_LOG2 = 6;
    localparam int DEF_WIDTH      = 8;

    // Input side handshake FSM: IDLE accepts, HOLD is the dead cycle.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } in_state_t;

    // Occupancy runs 0..2^depth_log2 inclusive, so it needs one extra bit.
    function automatic int level_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/tx_byte_fifo_if.sv
// tx_byte_fifo byte stream bundle: filter-side intake
// (avail/data/req) and UART-side drain (valid/data/done).
interface tx_byte_fifo_if #(
    parameter int WIDTH = 8
);

    logic             in_avail;
    logic [WIDTH-1:0] in_data;
    logic             in_req;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_done;

    // Environment side: filter upstream plus UART downstream.
    modport master (
        output in_avail,
        output in_data,
        output out_done,
        input  in_req,
        input  out_valid,
        input  out_data
    );

    // FIFO side.
    modport slave (
        input  in_avail,
        input  in_data,
        input  out_done,
        output in_req,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/tx_byte_fifo_mem.sv
// tx_byte_fifo storage: 2^DEPTH_LOG2 x WIDTH array with
// synchronous write and combinational read.
module tx_byte_fifo_mem
    import tx_byte_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int WIDTH      = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Contents are left unreset so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: elastic byte buffer from packet filter to UART.
// Optional high-water mark tracking: define TX_FIFO_HWM_EN.
module tx_byte_fifo
    import tx_byte_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int WIDTH      = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    tx_byte_fifo_if.slave       bus,
    output logic [DEPTH_LOG2:0] level,
    output logic                full,
    output logic                empty,
    output logic                underflow_err,
    input  logic                hwm_clr,
    output logic [DEPTH_LOG2:0] hwm
);

    localparam int LW = level_w(DEPTH_LOG2);

    localparam logic [LW-1:0] DEPTH =
        {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [LW-1:0] LVL_ONE =
        {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE =
        {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    in_state_t             state_q;
    in_state_t             state_d;
    logic                  push;
    logic                  pop;
    logic                  in_req_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_d;
    logic                  uf_q;
    logic [WIDTH-1:0]      rdata;

    // Flags come from the registered count, so a pop
    // never frees a slot for a push in the same cycle.
    assign full  = (level_q == DEPTH);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign pop   = bus.out_done && !empty;

    // Intake decision: take one byte from IDLE, then sit in HOLD a cycle.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_avail && !full) begin
                    push    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and the registered consume strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            in_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_req_q <= push;
        end
    end

    assign bus.in_req = in_req_q;

    // Occupancy update; push and pop together leave it unchanged.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally; the separate count disambiguates full/empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level_q <= level_d;
        end
    end

    // Sticky underflow: a new underflow wins over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uf_q <= 1'b0;
        end else if (bus.out_done && empty) begin
            uf_q <= 1'b1;
        end else if (hwm_clr) begin
            uf_q <= 1'b0;
        end
    end

    assign underflow_err = uf_q;

    tx_byte_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Stale storage is masked so an empty FIFO always shows zero.
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : rdata;

`ifdef TX_FIFO_HWM_EN
    logic [LW-1:0] hwm_q;

    // Peak tracking lags level by a cycle; a clear loads the post-push level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_q <= '0;
        end else if (hwm_clr) begin
            hwm_q <= level_d;
        end else if (level_q > hwm_q) begin
            hwm_q <= level_q;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_tx_byte_fifo.sv
// tx_byte_fifo bench: directed vectors plus a queue scoreboard,
// DEPTH_LOG2 = 2 so full and pointer wrap are reached quickly.
module tb_tx_byte_fifo;

    localparam int DL2 = 2;
    localparam int DEP = 4;

    logic       clk;
    logic       rst;
    logic       hwm_clr;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       underflow_err;
    logic [2:0] hwm;

    int n_chk;
    int n_err;

    logic [7:0] q[$];
    bit         m_idle;
    bit         m_uf;
    int         m_hwm;

    tx_byte_fifo_if #(.WIDTH(8)) bus ();

    tx_byte_fifo #(
        .DEPTH_LOG2 (DL2),
        .WIDTH      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .underflow_err (underflow_err),
        .hwm_clr       (hwm_clr),
        .hwm           (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_idle = 1'b1;
        m_uf   = 1'b0;
        m_hwm  = 0;
    endtask

    // One clock: drive at negedge, predict, check at the next negedge.
    task automatic cyc(input bit av, input logic [7:0] d,
                       input bit dn, input bit clr);
        bit ep;
        bit eo;
        int pre;
        bus.in_avail = av;
        bus.in_data  = d;
        bus.out_done = dn;
        hwm_clr      = clr;
        pre = q.size();
        ep  = m_idle && av && (pre < DEP);
        eo  = dn && (pre > 0);
        @(posedge clk);
        @(negedge clk);
        if (eo) q.delete(0);
        if (ep) q.push_back(d);
        m_idle = !ep;
        if (dn && !eo) m_uf = 1'b1;
        else if (clr)  m_uf = 1'b0;
        if (clr)            m_hwm = q.size();
        else if (pre > m_hwm) m_hwm = pre;
        chk("in_req", bus.in_req, ep);
        chk("level", level, q.size());
        chk("level_bound", level <= DEP, 1);
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("full", full, q.size() == DEP);
        chk("empty", empty, q.size() == 0);
        chk("underflow", underflow_err, m_uf);
        if (q.size() != 0) chk("out_data", bus.out_data, q[0]);
        else               chk("out_data0", bus.out_data, 0);
`ifdef TX_FIFO_HWM_EN
        chk("hwm", hwm, m_hwm);
`else
        chk("hwm_off", hwm, 0);
`endif
    endtask

    logic [7:0] src [100];
    logic [7:0] got [$];
    logic [7:0] exp3 [4];
    logic [7:0] head;
    logic [7:0] d;
    bit         hv;
    bit         av;
    bit         dn;
    int         k;
    int         n;
    int         idx;
    int         pulses;

    initial begin
        n_chk = 0;
        n_err = 0;
        model_reset();
        rst          = 1'b0;
        bus.in_avail = 1'b0;
        bus.in_data  = 8'h00;
        bus.out_done = 1'b0;
        hwm_clr      = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_req", bus.in_req, 0);
        rst = 1'b1;
        repeat (4) cyc(0, 8'h00, 0, 0);

        // Single byte
        cyc(1, 8'hA5, 0, 0);
        chk("t2_req", bus.in_req, 1);
        chk("t2_valid", bus.out_valid, 1);
        chk("t2_data", bus.out_data, 8'hA5);
        chk("t2_level", level, 1);
        cyc(0, 8'h00, 0, 0);
        chk("t2_req_drop", bus.in_req, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t2_empty", empty, 1);
        chk("t2_level0", level, 0);

        // Fill to full with 0x10..0x14 presented continuously
        idx = 0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1, 8'(8'h10 + idx), 0, 0);
            if (bus.in_req) begin
                idx++;
                pulses++;
            end
        end
        chk("t3_pulses", pulses, 4);
        chk("t3_full", full, 1);
        chk("t3_level", level, 4);
        chk("t3_head", bus.out_data, 8'h10);
        cyc(1, 8'h14, 1, 0);
        chk("t3_nopush", bus.in_req, 0);
        chk("t3_lvl3", level, 3);
        chk("t3_next", bus.out_data, 8'h11);
        cyc(1, 8'h14, 0, 0);
        chk("t3_push14", bus.in_req, 1);
        chk("t3_lvl4", level, 4);
        exp3 = '{8'h11, 8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", bus.out_data, exp3[i]);
            cyc(0, 8'h00, 1, 0);
        end
        chk("t3_drained", empty, 1);

        // Random traffic with wrap and same-cycle push/pop
        for (int i = 0; i < 100; i++) src[i] = 8'($urandom_range(0, 255));
        k = 0;
        n = 0;
        got.delete();
        while ((k < 100 || q.size() != 0) && n < 3000) begin
            av   = (k < 100) && ($urandom_range(0, 3) != 0);
            dn   = ($urandom_range(0, 1) != 0);
            d    = (k < 100) ? src[k] : 8'h00;
            head = bus.out_data;
            hv   = bus.out_valid;
            cyc(av, av ? d : 8'h00, dn, 0);
            if (dn && hv) got.push_back(head);
            if (bus.in_req) k++;
            n++;
        end
        chk("rand_done", (k == 100) && (q.size() == 0), 1);
        chk("rand_count", got.size(), 100);
        for (int i = 0; i < 100 && i < got.size(); i++) begin
            chk("rand_seq", got[i], src[i]);
        end

        // Underflow, sticky across traffic, cleared by hwm_clr
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t5_uf_set", underflow_err, 1);
        chk("t5_still_empty", empty, 1);
        cyc(1, 8'h33, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("t5_data", bus.out_data, 8'h33);
        cyc(0, 8'h00, 1, 0);
        chk("t5_uf_stick", underflow_err, 1);
        chk("t5_empty", empty, 1);
        cyc(0, 8'h00, 0, 1);
        chk("t5_uf_clr", underflow_err, 0);

        // Reset mid-operation
        cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h03, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("t6_level3", level, 3);
`ifdef TX_FIFO_HWM_EN
        chk("t6_hwm3", hwm, 3);
`endif
        bus.in_avail = 1'b1;
        bus.in_data  = 8'hEE;
        #2 rst = 1'b0;
        #1;
        chk("t6_empty", empty, 1);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_data0", bus.out_data, 0);
        chk("t6_level0", level, 0);
        chk("t6_hwm0", hwm, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_no_req", bus.in_req, 0);
        end
        rst = 1'b1;
        model_reset();
        cyc(1, 8'h5A, 0, 0);
        chk("t6_first", bus.out_data, 8'h5A);
        cyc(0, 8'h00, 0, 0);
        chk("t6_level1", level, 1);
`ifdef TX_FIFO_HWM_EN
        chk("t6_hwm1", hwm, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_byte_fifo.md
Name: tx_byte_fifo

Overview:
Elastic byte buffer between the packet filter output (DataAvail/DataVal/DataReq) and the UART transmitter (transmit/tx_byte/tx_done).
- Decouples bursty decoded trace bytes from the slow serial drain.
- Applies backpressure to the filter when full; the filter's own overflow logic then trips.
- Exports fill status for LEDs and debug.

Parameters:
DEPTH_LOG2, 6, log2 of FIFO depth (64 entries); legal range 2..10
WIDTH, 8, data width in bits

Ports:
clk  input  1  system clock (48 MHz)
rst  input  1  reset, asynchronous, active-low
in_avail  input  1  upstream flag: byte available on in_data
in_data  input  WIDTH  upstream byte value
in_req  output  1  single-cycle strobe: byte on in_data consumed this edge
out_valid  output  1  head byte present on out_data (to UART transmit)
out_data  output  WIDTH  head byte (to UART tx_byte)
out_done  input  1  single-cycle strobe from UART: head byte taken, pop
level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
full  output  1  level == 2^DEPTH_LOG2
empty  output  1  level == 0
underflow_err  output  1  sticky: out_done seen while empty
hwm_clr  input  1  clears hwm (and underflow_err)
hwm  output  DEPTH_LOG2+1  high-water mark of level (see Optional Feature)

Behaviour:
- Reset (rst low, async):
  - wr_ptr = rd_ptr = level = 0; empty = 1, full = 0.
  - in_req = 0, out_valid = 0, out_data = 0, underflow_err = 0, hwm = 0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all contents; no strobe is emitted after reset asserts.
- Input side: two-state FSM, all outputs registered.
  - IDLE:
    - If in_avail && !full: assert in_req for exactly one cycle, write in_data at wr_ptr on that edge, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD: one dead cycle, in_avail ignored, so the upstream can deassert or update its flag; then return to IDLE.
  - Maximum intake is therefore one byte per 2 cycles.
  - full is evaluated on the registered level. A pop in the same cycle does not enable a push that cycle.
- Output side:
  - out_valid = !empty. out_data = mem[rd_ptr], valid from the cycle after a write into an empty FIFO (1-cycle first-word latency).
  - out_data is held stable while out_valid is high and no out_done occurs.
  - out_done && !empty: rd_ptr increments; the next head appears the following cycle.
  - out_done && empty: ignored for pointers; underflow_err set (sticky until hwm_clr or reset).
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. level is a separate counter, so full and empty are unambiguous at wrap.
- Invariant: level never exceeds depth or goes below 0. Violation is a bug; the bench asserts on it.

Optional Feature:
Macro TX_FIFO_HWM_EN.
- Defined: hwm registers max(level) seen since reset/hwm_clr, updated the cycle after level changes. hwm_clr sets hwm to the current level. If hwm_clr and a push occur in the same cycle, the post-push level wins.
- Undefined: hwm is tied to 0, no tracking logic is synthesised, and hwm_clr clears only underflow_err.

Decomposition:
- Shared package holds:
  - default DEPTH_LOG2 and WIDTH constants;
  - input FSM state encoding (IDLE = 0, HOLD = 1);
  - LEVEL_W = DEPTH_LOG2+1 helper.
- One sub-module: tx_byte_fifo_mem.
  - 2^DEPTH_LOG2 x WIDTH array, synchronous write, combinational read at rd_ptr; maps to iCE40 block RAM or LUTs.
  - Pointers, level, FSM and flags stay in the parent.

Test Plan:
- Reset then idle: rst low 3 cycles, release; no stimulus -> empty=1, level=0, out_valid=0, in_req never pulses.
- Single byte: in_avail=1, in_data=0xA5, drop in_avail on in_req -> in_req one cycle, out_valid=1 with out_data=0xA5 next cycle, level=1. Pulse out_done -> empty=1, level=0.
- Fill to full, DEPTH_LOG2=2: present 0x10..0x14 continuously, no out_done -> exactly 4 in_req pulses spaced 2 cycles apart, full=1, level=4, 0x14 not taken. One out_done -> 0x14 accepted, output order 0x10,0x11,...
- Wrap plus simultaneous events: 100 random bytes with random out_done, including same-cycle push/pop -> output sequence equals input sequence, level matches the scoreboard every cycle.
- Underflow: out_done while empty -> underflow_err=1 and stays set after later traffic. hwm_clr pulse -> 0. Pointers unaffected.
- Reset mid-operation: level=3, assert rst -> immediately empty=1, out_valid=0. After release, new byte 0x5A is the first out. With TX_FIFO_HWM_EN: hwm=3 before reset, 0 after, and 1 after the new byte.
